inst_rom_resp: RTL and testbench

Responder side of the PC-to-instruction-memory interface. Accepts the fetch address and chip enable driven by the PC register and returns a 32-bit instruction word with a valid flag after a fixed latency. A boot phase after reset lets a loader fill the word array through a write port before fetches are served. Sits between the PC register and the IF/ID pipeline register.

---
 rtl/inst_rom_resp_pkg.sv | 29 ++
 rtl/inst_rom_pipe.sv | 32 +++
 rtl/inst_rom_resp.sv | 98 +++++++++
 tb/tb_inst_rom_resp.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/inst_rom_resp_pkg.sv
// Shared widths, words and state encodings for the instruction ROM responder.
// Also provides the fetch/write address legality check used by the top.
package inst_rom_resp_pkg;

  localparam int InstAddrBus    = 32;
  localparam int InstBus        = 32;
  localparam int DefaultAwWords = 10;

  localparam logic [InstBus-1:0] ZeroWord = 32'h0000_0000;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } rom_state_e;

  typedef struct packed {
    logic               valid;
    logic               err;
    logic [InstBus-1:0] data;
  } rom_resp_t;

  // A byte address is unusable if misaligned or beyond the word array; never aliased.
  function automatic logic addr_bad(input logic [InstAddrBus-1:0] a, input int aw_words);
    logic [InstAddrBus-1:0] upper;
    upper    = a >> (aw_words + 2);
    addr_bad = (a[1:0] != 2'b00) || (upper != {InstAddrBus{1'b0}});
  endfunction

endpackage

// File: rtl/inst_rom_pipe.sv
// LATENCY-deep register chain carrying {valid, err, data} for fetch responses.
// Synchronous flush on rst drops anything in flight.
module inst_rom_pipe
  import inst_rom_resp_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  rom_resp_t d,
  output rom_resp_t q
);

  rom_resp_t stage [LATENCY];

  // Shift responses one stage per cycle; stage 0 captures the new request.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < LATENCY; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[LATENCY-1];

endmodule

// File: rtl/inst_rom_resp.sv
// Instruction memory responder: boot-time loader fills the array, then fetches are
// served read-only with a fixed, fully pipelined latency.
module inst_rom_resp
  import inst_rom_resp_pkg::*;
#(
  parameter int AW_WORDS = DefaultAwWords,
  parameter int LATENCY  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic [InstAddrBus-1:0] addr,
  input  logic                   wr_en,
  input  logic [InstAddrBus-1:0] wr_addr,
  input  logic [InstBus-1:0]     wr_data,
  input  logic                   boot_done,
  output logic                   ready,
  output logic [InstBus-1:0]     inst,
  output logic                   inst_valid,
  output logic                   addr_err
);

  localparam int Depth = 2 ** AW_WORDS;

  rom_state_e         state;
  logic [InstBus-1:0] mem [Depth];
  rom_resp_t          req;
  rom_resp_t          resp;
  logic               wr_ok;

  assign wr_ok = !rst && (state == BOOT) && wr_en && !addr_bad(wr_addr, AW_WORDS);

  // Boot/run state and the ready flag, which mirrors the state it will hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
      ready <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          if (boot_done) begin
            state <= RUN;
            ready <= 1'b1;
          end else begin
            state <= BOOT;
            ready <= 1'b0;
          end
        end
        RUN: begin
          state <= RUN;
          ready <= 1'b1;
        end
        default: begin
          state <= BOOT;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // Loader writes; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr[AW_WORDS+1:2]] <= wr_data;
    end
  end

  // Build the first-stage response; the array is read at request time.
  always_comb begin
    req = '0;
    if ((state == RUN) && ce) begin
      req.valid = 1'b1;
      if (addr_bad(addr, AW_WORDS)) begin
        req.err  = 1'b1;
        req.data = ZeroWord;
      end else begin
        req.err  = 1'b0;
        req.data = mem[addr[AW_WORDS+1:2]];
      end
    end else begin
      req = '0;
    end
  end

  inst_rom_pipe #(
    .LATENCY(LATENCY)
  ) u_pipe (
    .clk(clk),
    .rst(rst),
    .d  (req),
    .q  (resp)
  );

  assign inst       = resp.data;
  assign inst_valid = resp.valid;
  assign addr_err   = resp.err;

endmodule

// File: tb/tb_inst_rom_resp.sv
// Self-checking bench: two responders (LATENCY 1 and 3) share one stimulus stream,
// each checked against its own scoreboard queue fed by a reference memory model.
module tb_inst_rom_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [31:0] addr;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        boot_done;

  logic        ready1, inst_valid1, addr_err1;
  logic [31:0] inst1;
  logic        ready3, inst_valid3, addr_err3;
  logic [31:0] inst3;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_m [1024];
  logic        run_m;
  logic [33:0] q1 [$];
  logic [33:0] q3 [$];

  always #5 clk = ~clk;

  inst_rom_resp #(.AW_WORDS(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .boot_done(boot_done), .ready(ready1), .inst(inst1),
    .inst_valid(inst_valid1), .addr_err(addr_err1)
  );

  inst_rom_resp #(.AW_WORDS(10), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .boot_done(boot_done), .ready(ready3), .inst(inst3),
    .inst_valid(inst_valid3), .addr_err(addr_err3)
  );

  function automatic logic bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:12] != 20'h0);
  endfunction

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic c, input logic [31:0] a, input logic we,
                      input logic [31:0] wa, input logic [31:0] wd, input logic bd);
    logic [33:0] e;
    logic [33:0] exp1;
    logic [33:0] exp3;
    rst = r; ce = c; addr = a; wr_en = we; wr_addr = wa; wr_data = wd; boot_done = bd;
    @(posedge clk);
    if (r) begin
      run_m = 1'b0;
      q1.delete();
      q3 = '{34'h0, 34'h0};
      exp1 = 34'h0;
      exp3 = 34'h0;
    end else begin
      e = 34'h0;
      if (run_m && c) begin
        if (bad_addr(a)) e = {1'b1, 1'b1, 32'h0};
        else             e = {1'b1, 1'b0, mem_m[a[11:2]]};
      end
      if (!run_m && we && !bad_addr(wa)) mem_m[wa[11:2]] = wd;
      if (!run_m && bd) run_m = 1'b1;
      q1.push_back(e);
      exp1 = q1.pop_front();
      q3.push_back(e);
      exp3 = q3.pop_front();
    end
    #1;
    chk("resp_lat1", {inst_valid1, addr_err1, inst1}, exp1);
    chk("resp_lat3", {inst_valid3, addr_err3, inst3}, exp3);
    chk("ready_lat1", {33'h0, ready1}, {33'h0, run_m});
    chk("ready_lat3", {33'h0, ready3}, {33'h0, run_m});
  endtask

  task automatic fetch(input logic [31:0] a);
    step(1'b0, 1'b1, a, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic write(input logic [31:0] wa, input logic [31:0] wd, input logic bd);
    step(1'b0, 1'b0, 32'h0, 1'b1, wa, wd, bd);
  endtask

  initial begin
    run_m = 1'b0;
    rst = 1'b1; ce = 1'b0; addr = 32'h0; wr_en = 1'b0;
    wr_addr = 32'h0; wr_data = 32'h0; boot_done = 1'b0;

    // reset, then idle in BOOT: ce must be ignored
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) fetch(32'h0);

    // boot loading, including dropped misaligned / out-of-range writes
    write(32'h0000_0000, 32'h3401_1100, 1'b0);
    write(32'h0000_0004, 32'h3402_0020, 1'b0);
    write(32'h0000_0008, 32'h3403_ff00, 1'b0);
    write(32'h0000_000C, 32'h3404_ffff, 1'b0);
    write(32'h0000_0FFC, 32'hdead_beef, 1'b0);
    write(32'h0000_0006, 32'h1111_1111, 1'b0);
    write(32'h0000_1004, 32'h2222_2222, 1'b0);

    // rst together with boot_done stays in BOOT
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    idle();

    // write of word 5 coincident with boot_done
    write(32'h0000_0014, 32'h3405_abcd, 1'b1);

    // back-to-back fetches, bubbles, errors and boundary word
    fetch(32'h0); fetch(32'h4); fetch(32'h8); fetch(32'hC);
    idle();
    fetch(32'h0); idle(); fetch(32'h4);
    fetch(32'h0000_0002);
    fetch(32'h0000_1000);
    fetch(32'h0000_0FFC);
    fetch(32'h0000_0014);
    fetch(32'h8000_0000);
    for (int i = 0; i < 3; i++) idle();

    // mid-operation reset drops in-flight requests but keeps contents
    fetch(32'h0); fetch(32'h4); fetch(32'h8);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    fetch(32'h0); fetch(32'h4);
    for (int i = 0; i < 3; i++) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
